// File: rtl/sha256_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg
// Shared SHA-256 definitions used by the message scheduler and by the
// compression core: size limits, scheduler state encoding, the initial hash
// value and the bit-mixing functions of the algorithm.
// No ports (package).
// ---------------------------------------------------------------------------
package sha256_pkg;

  // A padded single block holds 64 bytes: message, the 0x80 marker byte and
  // an 8-byte length field, which leaves room for at most 55 message bytes.
  localparam int SHA256_MAX_STRING_SIZE = 55;
  localparam int SHA256_WORD_W          = 32;
  localparam int SHA256_ROUNDS          = 64;
  localparam logic [5:0] SHA256_LAST_INDEX = 6'd63;

  // Scheduler states: IDLE waits for a message, RUN streams W[0..63].
  typedef enum logic {
    SCHED_IDLE = 1'b0,
    SCHED_RUN  = 1'b1
  } sched_state_e;

  // Initial hash value H0..H7 (H0 in the most significant word).
  localparam logic [255:0] SHA256_H_INIT = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Rotate right by a constant amount; a zero amount returns x unchanged
  // because the left shift by 32 yields zero.
  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Small sigma functions of the message schedule.
  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Big sigma, choose and majority functions of the compression rounds.
  function automatic logic [31:0] bigSigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bigSigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] choose(input logic [31:0] e, input logic [31:0] f,
                                         input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] majority(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_w_expand.sv
// ---------------------------------------------------------------------------
// sha256_w_expand
// Combinational calculator for the next message schedule word:
//   W[t] = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16]  (mod 2^32)
// Ports:
//   i_wTm2    W[t-2]   (window slot 14)
//   i_wTm7    W[t-7]   (window slot 9)
//   i_wTm15   W[t-15]  (window slot 1)
//   i_wTm16   W[t-16]  (window slot 0)
//   o_newWord W[t]
// ---------------------------------------------------------------------------
module sha256_w_expand
  import sha256_pkg::*;
(
  input  logic [31:0] i_wTm2,
  input  logic [31:0] i_wTm7,
  input  logic [31:0] i_wTm15,
  input  logic [31:0] i_wTm16,
  output logic [31:0] o_newWord
);

  // Four-operand modular sum; the 32-bit result width discards the carries.
  always_comb begin
    o_newWord = sigma1(i_wTm2) + i_wTm7 + sigma0(i_wTm15) + i_wTm16;
  end

endmodule

// File: rtl/sha256_msg_sched.sv
// ---------------------------------------------------------------------------
// sha256_msg_sched
// Single-block SHA-256 message scheduler. Accepts one pre-marked message of
// up to MAX_STRING_SIZE bytes, builds the 16-word initial window (message
// words, a zero word and the bit length) and streams W[0..63] with a
// valid/ready handshake, one word per cycle when unstalled.
// Ports:
//   aclk, areset            clock, asynchronous active-high reset
//   string_w0..string_w13   big-endian message words, 0x80 marker included
//   string_size             message length in bytes
//   string_dv/string_ready  upstream offer handshake
//   size_error              one-cycle pulse when an oversized offer is refused
//   w_data/w_index          schedule word W[t] and its index t
//   w_valid/w_ready         downstream handshake
//   w_last                  marks t = 63
//   busy                    a schedule is in progress
// ---------------------------------------------------------------------------
module sha256_msg_sched
  import sha256_pkg::*;
#(
  parameter int MAX_STRING_SIZE = SHA256_MAX_STRING_SIZE
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] string_w0,
  input  logic [31:0] string_w1,
  input  logic [31:0] string_w2,
  input  logic [31:0] string_w3,
  input  logic [31:0] string_w4,
  input  logic [31:0] string_w5,
  input  logic [31:0] string_w6,
  input  logic [31:0] string_w7,
  input  logic [31:0] string_w8,
  input  logic [31:0] string_w9,
  input  logic [31:0] string_w10,
  input  logic [31:0] string_w11,
  input  logic [31:0] string_w12,
  input  logic [31:0] string_w13,
  input  logic [7:0]  string_size,
  input  logic        string_dv,
  output logic        string_ready,
  output logic        size_error,
  output logic [31:0] w_data,
  output logic [5:0]  w_index,
  output logic        w_valid,
  output logic        w_last,
  input  logic        w_ready,
  output logic        busy
);

  localparam logic [7:0] MAX_SIZE_BYTES = 8'(MAX_STRING_SIZE);

  sched_state_e r_state;
  sched_state_e w_nextState;
  logic [31:0]  r_window [0:15];
  logic [5:0]   r_tCount;
  logic         r_sizeError;
  logic [31:0]  w_stringWords [0:13];
  logic [31:0]  w_newWord;
  logic         w_sizeOk;
  logic         w_atLast;
  logic         w_load;
  logic         w_reject;
  logic         w_beat;

  // Gather the message inputs into an array so the load is a simple loop.
  assign w_stringWords[0]  = string_w0;
  assign w_stringWords[1]  = string_w1;
  assign w_stringWords[2]  = string_w2;
  assign w_stringWords[3]  = string_w3;
  assign w_stringWords[4]  = string_w4;
  assign w_stringWords[5]  = string_w5;
  assign w_stringWords[6]  = string_w6;
  assign w_stringWords[7]  = string_w7;
  assign w_stringWords[8]  = string_w8;
  assign w_stringWords[9]  = string_w9;
  assign w_stringWords[10] = string_w10;
  assign w_stringWords[11] = string_w11;
  assign w_stringWords[12] = string_w12;
  assign w_stringWords[13] = string_w13;

  assign w_sizeOk   = (string_size <= MAX_SIZE_BYTES);
  assign w_atLast   = (r_tCount == SHA256_LAST_INDEX);
  assign w_data     = r_window[0];
  assign w_index    = r_tCount;
  assign size_error = r_sizeError;

  // The window slots feeding the recurrence are fixed: slot 14 holds
  // W[t-2], slot 9 W[t-7], slot 1 W[t-15] and slot 0 W[t-16] relative to the
  // word being generated into slot 15.
  sha256_w_expand u_expand (
    .i_wTm2    (r_window[14]),
    .i_wTm7    (r_window[9]),
    .i_wTm15   (r_window[1]),
    .i_wTm16   (r_window[0]),
    .o_newWord (w_newWord)
  );

  // State register: reset always lands in IDLE, aborting any schedule.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= SCHED_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake decode. IDLE only offers string_ready and
  // either loads a message or flags it as oversized. RUN presents the head
  // of the window and advances on each beat; the beat on t = 63 goes back
  // to IDLE so the next offer can be taken in the following cycle. String
  // inputs are never looked at while in RUN.
  always_comb begin
    w_nextState  = r_state;
    string_ready = 1'b0;
    w_valid      = 1'b0;
    busy         = 1'b0;
    w_last       = 1'b0;
    w_load       = 1'b0;
    w_reject     = 1'b0;
    w_beat       = 1'b0;
    case (r_state)
      SCHED_IDLE: begin
        string_ready = 1'b1;
        if (string_dv) begin
          if (w_sizeOk) begin
            w_load      = 1'b1;
            w_nextState = SCHED_RUN;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      SCHED_RUN: begin
        w_valid = 1'b1;
        busy    = 1'b1;
        w_last  = w_atLast;
        if (w_ready) begin
          w_beat = 1'b1;
          if (w_atLast) begin
            w_nextState = SCHED_IDLE;
          end
        end
      end
      default: begin
        w_nextState = SCHED_IDLE;
      end
    endcase
  end

  // Sliding window of sixteen words. A load builds the padded block tail
  // (zero word, then the message length in bits); each beat shifts the
  // window toward slot 0 and appends the freshly computed word. During a
  // stall nothing moves, so w_data stays put.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < 16; i++) begin
        r_window[i] <= '0;
      end
    end else if (w_load) begin
      for (int i = 0; i < 14; i++) begin
        r_window[i] <= w_stringWords[i];
      end
      r_window[14] <= '0;
      r_window[15] <= {21'd0, string_size, 3'd0};
    end else if (w_beat) begin
      for (int i = 0; i < 15; i++) begin
        r_window[i] <= r_window[i+1];
      end
      r_window[15] <= w_newWord;
    end
  end

  // Word index t. It restarts on every load; the increment after t = 63
  // wraps to zero, which is also the idle value.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_tCount <= '0;
    end else if (w_load) begin
      r_tCount <= '0;
    end else if (w_beat) begin
      r_tCount <= r_tCount + 6'd1;
    end
  end

  // Refusal flag: registered so it is a clean single-cycle pulse following
  // the refused offer.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_sizeError <= 1'b0;
    end else begin
      r_sizeError <= w_reject;
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// ---------------------------------------------------------------------------
// tb_sha256_msg_sched
// Directed and randomized bench for sha256_msg_sched. Expected schedules
// come from a reference built with the textbook recurrence over a plain
// 64-entry array.
// ---------------------------------------------------------------------------
module tb_sha256_msg_sched;

  logic        aclk;
  logic        areset;
  logic [31:0] string_w0, string_w1, string_w2, string_w3, string_w4;
  logic [31:0] string_w5, string_w6, string_w7, string_w8, string_w9;
  logic [31:0] string_w10, string_w11, string_w12, string_w13;
  logic [7:0]  string_size;
  logic        string_dv;
  logic        string_ready;
  logic        size_error;
  logic [31:0] w_data;
  logic [5:0]  w_index;
  logic        w_valid;
  logic        w_last;
  logic        w_ready;
  logic        busy;

  int          checks;
  int          errors;
  int          cycles;
  logic [31:0] msgWords [14];
  logic [31:0] expW [64];
  logic [31:0] obsW [64];

  sha256_msg_sched #(.MAX_STRING_SIZE(55)) dut (
    .aclk         (aclk),
    .areset       (areset),
    .string_w0    (string_w0),
    .string_w1    (string_w1),
    .string_w2    (string_w2),
    .string_w3    (string_w3),
    .string_w4    (string_w4),
    .string_w5    (string_w5),
    .string_w6    (string_w6),
    .string_w7    (string_w7),
    .string_w8    (string_w8),
    .string_w9    (string_w9),
    .string_w10   (string_w10),
    .string_w11   (string_w11),
    .string_w12   (string_w12),
    .string_w13   (string_w13),
    .string_size  (string_size),
    .string_dv    (string_dv),
    .string_ready (string_ready),
    .size_error   (size_error),
    .w_data       (w_data),
    .w_index      (w_index),
    .w_valid      (w_valid),
    .w_last       (w_last),
    .w_ready      (w_ready),
    .busy         (busy)
  );

  // Free-running 100 MHz clock.
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Reference rotate and schedule sigmas, straight from the algorithm text.
  function automatic logic [31:0] refRotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] refSmallSigma0(input logic [31:0] x);
    return refRotr(x, 7) ^ refRotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] refSmallSigma1(input logic [31:0] x);
    return refRotr(x, 17) ^ refRotr(x, 19) ^ (x >> 10);
  endfunction

  // One comparison: counts it, and on a miss counts and reports the failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Full 64-word schedule for the block held in msgWords.
  task automatic buildReference(input logic [7:0] size);
    for (int i = 0; i < 14; i++) expW[i] = msgWords[i];
    expW[14] = 32'd0;
    expW[15] = 32'(size) * 32'd8;
    for (int t = 16; t < 64; t++) begin
      expW[t] = refSmallSigma1(expW[t-2]) + expW[t-7] + refSmallSigma0(expW[t-15]) + expW[t-16];
    end
  endtask

  // Present msgWords/size as an offer for one edge.
  task automatic applyStimulus(input logic [7:0] size, input bit holdDv);
    string_w0  = msgWords[0];
    string_w1  = msgWords[1];
    string_w2  = msgWords[2];
    string_w3  = msgWords[3];
    string_w4  = msgWords[4];
    string_w5  = msgWords[5];
    string_w6  = msgWords[6];
    string_w7  = msgWords[7];
    string_w8  = msgWords[8];
    string_w9  = msgWords[9];
    string_w10 = msgWords[10];
    string_w11 = msgWords[11];
    string_w12 = msgWords[12];
    string_w13 = msgWords[13];
    string_size = size;
    string_dv   = 1'b1;
    tick();
    if (!holdDv) string_dv = 1'b0;
  endtask

  task automatic setAbc();
    for (int i = 0; i < 14; i++) msgWords[i] = 32'd0;
    msgWords[0] = 32'h61626380;
  endtask

  // Consume words until stopAt have been accepted. readyMode: 0 always
  // ready, 1 ready on alternate cycles starting high, 2 random ready.
  task automatic collectSchedule(input int readyMode, input int stopAt, input bit toggleDv,
                                 output int nCycles);
    int idx;
    idx = 0;
    nCycles = 0;
    while (idx < stopAt && nCycles < 1000) begin
      case (readyMode)
        0:       w_ready = 1'b1;
        1:       w_ready = ((nCycles % 2) == 0);
        default: w_ready = 1'($urandom_range(1, 0));
      endcase
      if (toggleDv) begin
        string_dv   = ((nCycles % 2) == 0);
        string_w0   = $urandom;
        string_w5   = $urandom;
        string_w13  = $urandom;
        string_size = 8'($urandom_range(55, 0));
        checkOutput("ready_in_run", 32'(string_ready), 32'd0);
      end
      checkOutput("w_valid_run", 32'(w_valid), 32'd1);
      checkOutput("w_data", w_data, expW[idx]);
      checkOutput("w_index", 32'(w_index), 32'(idx));
      checkOutput("w_last", 32'(w_last), 32'(idx == 63));
      if (w_ready) begin
        obsW[idx] = w_data;
        idx++;
      end
      nCycles++;
      tick();
    end
    w_ready = 1'b0;
    if (toggleDv) string_dv = 1'b0;
    checkOutput("schedule_budget", 32'(idx), 32'(stopAt));
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_valid"}, 32'(w_valid), 32'd0);
    checkOutput({tag, "_ready"}, 32'(string_ready), 32'd1);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic checkReject(input logic [7:0] size);
    applyStimulus(size, 1'b0);
    checkOutput("size_error_pulse", 32'(size_error), 32'd1);
    checkIdle("reject");
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("size_error_clear", 32'(size_error), 32'd0);
      checkIdle("reject_after");
    end
  endtask

  initial begin
    logic [7:0] rndSize;
    checks = 0;
    errors = 0;
    areset = 1'b1;
    string_dv = 1'b0;
    w_ready = 1'b0;
    string_size = 8'd0;
    for (int i = 0; i < 14; i++) msgWords[i] = 32'd0;
    {string_w0, string_w1, string_w2, string_w3, string_w4, string_w5, string_w6} = '0;
    {string_w7, string_w8, string_w9, string_w10, string_w11, string_w12, string_w13} = '0;

    // Reset state.
    #2;
    checkOutput("rst_valid", 32'(w_valid), 32'd0);
    checkOutput("rst_last", 32'(w_last), 32'd0);
    checkOutput("rst_size_error", 32'(size_error), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    areset = 1'b0;
    #1;
    checkIdle("post_reset");
    checkOutput("rst_index", 32'(w_index), 32'd0);
    checkOutput("rst_data", w_data, 32'd0);

    // "abc" with w_ready held high.
    $display("[TB] abc, no stalls");
    setAbc();
    buildReference(8'd3);
    applyStimulus(8'd3, 1'b0);
    checkOutput("latency_valid", 32'(w_valid), 32'd1);
    collectSchedule(0, 64, 1'b0, cycles);
    checkOutput("abc_cycles", 32'(cycles), 32'd64);
    checkOutput("abc_W0", obsW[0], 32'h61626380);
    checkOutput("abc_W15", obsW[15], 32'h00000018);
    checkOutput("abc_W16", obsW[16], 32'h61626380);
    checkOutput("abc_W17", obsW[17], 32'h000F0000);
    checkOutput("abc_W18", obsW[18], 32'h7DA86405);
    checkIdle("abc_end");

    // "abc" with w_ready alternating.
    $display("[TB] abc, alternating ready");
    applyStimulus(8'd3, 1'b0);
    collectSchedule(1, 64, 1'b0, cycles);
    checkOutput("stall_cycles", 32'(cycles), 32'd127);
    checkIdle("stall_end");

    // Oversized offers are refused.
    $display("[TB] oversized offers");
    checkReject(8'd56);
    checkReject(8'd200);

    // Random messages, random ready, including the largest legal size.
    $display("[TB] random messages");
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 14; i++) msgWords[i] = $urandom;
      rndSize = (r == 0) ? 8'd55 : 8'($urandom_range(55, 0));
      buildReference(rndSize);
      applyStimulus(rndSize, 1'b0);
      collectSchedule(2, 64, 1'b0, cycles);
      checkIdle("random_end");
    end

    // Reset in the middle of a schedule.
    $display("[TB] reset mid-run");
    setAbc();
    buildReference(8'd3);
    applyStimulus(8'd3, 1'b0);
    collectSchedule(0, 30, 1'b0, cycles);
    checkOutput("pre_abort_index", 32'(w_index), 32'd30);
    areset = 1'b1;
    #1;
    checkOutput("abort_valid", 32'(w_valid), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_index", 32'(w_index), 32'd0);
    tick();
    areset = 1'b0;
    tick();
    checkIdle("abort_idle");
    applyStimulus(8'd3, 1'b0);
    checkOutput("restart_W0", w_data, 32'h61626380);
    collectSchedule(0, 64, 1'b0, cycles);
    checkIdle("restart_end");

    // New offers during RUN must be ignored.
    $display("[TB] offers during run");
    applyStimulus(8'd3, 1'b0);
    collectSchedule(0, 64, 1'b1, cycles);
    checkIdle("dv_toggle_end");

    // Back-to-back offers with string_dv held high.
    $display("[TB] back-to-back");
    applyStimulus(8'd3, 1'b1);
    collectSchedule(0, 64, 1'b0, cycles);
    checkIdle("b2b_gap");
    tick();
    checkOutput("b2b_valid", 32'(w_valid), 32'd1);
    checkOutput("b2b_index", 32'(w_index), 32'd0);
    checkOutput("b2b_W0", w_data, 32'h61626380);
    string_dv = 1'b0;
    collectSchedule(0, 64, 1'b0, cycles);
    checkIdle("b2b_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
